// File: rtl/ramm_pkg.sv
// Shared defaults and types for the ramm scratch memory.
// DEPTH is derived from ADDR_W so the two can never disagree.
package ramm_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ramm.sv
// Single-port synchronous RAM with one shared address bus.
// Reads land on a registered output one clock after the address is presented.
module ramm
   import ramm_pkg::*;
#(
   parameter int ADDR_W = ramm_pkg::ADDR_W,
   parameter int DATA_W = ramm_pkg::DATA_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] reddat
);

   // Array carries no reset so it maps onto block or distributed RAM.
   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= data;
      end
   end

   // Output register only loads on read cycles; it holds across writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reddat <= '0;
      end else if (!we) begin
         reddat <= mem[addr];
      end
   end

endmodule

// File: tb/tb_ramm.sv
// Self-checking bench for ramm: directed scenarios followed by randomized
// traffic checked against a simple array model of the memory.
module tb_ramm;
   import ramm_pkg::*;

   logic  clk;
   logic  rst;
   addr_t addr;
   logic  we;
   data_t data;
   data_t reddat;

   int assertions = 0;
   int failures   = 0;

   // Behavioural model: word array plus the value a read is expected to return.
   data_t model_mem [DEPTH];
   bit    written   [DEPTH];
   data_t exp_rd;

   ramm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .we     (we),
      .data   (data),
      .reddat (reddat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one transaction, waits for its edge, samples 1 time unit later.
   task automatic step(input addr_t a, input logic w, input data_t d);
      addr = a;
      we   = w;
      data = d;
      @(posedge clk);
      #1;
      if (w) begin
         model_mem[a] = d;
         written[a]   = 1'b1;
      end else begin
         exp_rd = model_mem[a];
      end
      $display("txn %s addr=%02h data=%02h reddat=%02h",
               w ? "WR" : "RD", a, d, reddat);
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      assertions++;
      if (reddat !== 8'h00) begin
         failures++;
         $display("FAIL reset_async reddat=%02h expected=00", reddat);
      end
      step(6'h10, 1'b0, 8'h00);
      step(6'h11, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h00) begin
         failures++;
         $display("FAIL reset_held reddat=%02h expected=00", reddat);
      end
      rst = 1'b0;
      #1;
      assertions++;
      if (reddat !== 8'h00) begin
         failures++;
         $display("FAIL reset_release reddat=%02h expected=00", reddat);
      end
      step(6'h10, 1'b1, 8'h77);
      assertions++;
      if (reddat !== 8'h00) begin
         failures++;
         $display("FAIL reset_hold_after_write reddat=%02h expected=00", reddat);
      end
      step(6'h10, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h77) begin
         failures++;
         $display("FAIL reset_first_read reddat=%02h expected=77", reddat);
      end
   endtask

   task automatic test_basic();
      step(6'h2F, 1'b1, 8'b10101111);
      assertions++;
      if (reddat !== 8'h77) begin
         failures++;
         $display("FAIL basic_write_hold reddat=%02h expected=77", reddat);
      end
      step(6'h2F, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'hAF) begin
         failures++;
         $display("FAIL basic_read reddat=%02h expected=AF", reddat);
      end
   endtask

   task automatic test_hold_on_write();
      step(6'h00, 1'b1, 8'h55);
      assertions++;
      if (reddat !== 8'hAF) begin
         failures++;
         $display("FAIL hold_on_write reddat=%02h expected=AF", reddat);
      end
      step(6'h00, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h55) begin
         failures++;
         $display("FAIL read_after_write reddat=%02h expected=55", reddat);
      end
   endtask

   task automatic test_boundary();
      step(6'h00, 1'b1, 8'h01);
      step(6'h3F, 1'b1, 8'hFE);
      step(6'h00, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h01) begin
         failures++;
         $display("FAIL boundary_low reddat=%02h expected=01", reddat);
      end
      step(6'h3F, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'hFE) begin
         failures++;
         $display("FAIL boundary_high reddat=%02h expected=FE", reddat);
      end
   endtask

   task automatic test_back_to_back();
      step(6'h2F, 1'b1, 8'hAF);
      step(6'h2F, 1'b1, 8'h3C);
      step(6'h2F, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h3C) begin
         failures++;
         $display("FAIL b2b_overwrite reddat=%02h expected=3C", reddat);
      end
      step(6'h00, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'h01) begin
         failures++;
         $display("FAIL b2b_low reddat=%02h expected=01", reddat);
      end
      step(6'h3F, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'hFE) begin
         failures++;
         $display("FAIL b2b_high reddat=%02h expected=FE", reddat);
      end
   endtask

   task automatic test_reset_preserves();
      we = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      assertions++;
      if (reddat !== 8'h00) begin
         failures++;
         $display("FAIL pulse_reset reddat=%02h expected=00", reddat);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(6'h3F, 1'b0, 8'h00);
      assertions++;
      if (reddat !== 8'hFE) begin
         failures++;
         $display("FAIL reset_preserves reddat=%02h expected=FE", reddat);
      end
   endtask

   task automatic test_random();
      addr_t a;
      logic  w;
      data_t d;
      data_t hold;
      for (int i = 0; i < 300; i++) begin
         a    = addr_t'($urandom_range(DEPTH - 1, 0));
         d    = data_t'($urandom);
         w    = ($urandom_range(1, 0) == 1) || !written[a];
         hold = reddat;
         step(a, w, d);
         assertions++;
         if (w) begin
            if (reddat !== hold) begin
               failures++;
               $display("FAIL rand_write_hold i=%0d reddat=%02h expected=%02h", i, reddat, hold);
            end
         end else if (reddat !== exp_rd) begin
            failures++;
            $display("FAIL rand_read i=%0d addr=%02h reddat=%02h expected=%02h", i, a, reddat, exp_rd);
         end
      end
   endtask

   initial begin
      rst    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      data   = '0;
      exp_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         written[i]   = 1'b0;
      end
      test_reset();
      test_basic();
      test_hold_on_write();
      test_boundary();
      test_back_to_back();
      test_reset_preserves();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
